// File: rtl/zeroheti_obi_sram_sbr.sv
// rtl/zeroheti_obi_sram_sbr.sv - OBI subordinate serving SBA traffic from a 1-cycle-latency SRAM
// Optional: ZEROHETI_OBI_SRAM_ALIGN_ERR_EN answers misaligned addresses with err=1.
module zeroheti_obi_sram_sbr #(
  parameter logic [31:0] BaseAddr   = 32'h0001_0000,
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned WaitCycles = 0,
  parameter int unsigned AidWidth   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        obi_req_i,
  output logic                        obi_gnt_o,
  input  logic [31:0]                 obi_addr_i,
  input  logic                        obi_we_i,
  input  logic [3:0]                  obi_be_i,
  input  logic [31:0]                 obi_wdata_i,
  input  logic [AidWidth-1:0]         obi_aid_i,
  output logic                        obi_rvalid_o,
  output logic [31:0]                 obi_rdata_o,
  output logic [AidWidth-1:0]         obi_rid_o,
  output logic                        obi_err_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [$clog2(NumWords)-1:0] mem_addr_o,
  output logic [3:0]                  mem_be_o,
  output logic [31:0]                 mem_wdata_o,
  input  logic [31:0]                 mem_rdata_i
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam logic [32:0] WinLo = {1'b0, BaseAddr};
  localparam logic [32:0] WinHi = WinLo + (33'(NumWords) * 33'd4);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [AidWidth-1:0]   aid_q, aid_d;
  logic                  in_range_q, in_range_d;

  logic [32:0]           addr_ext;
  logic [IdxW+1:0]       offset;
  logic                  in_window;
  logic                  in_range;
  logic                  unused_offset_lsb;

  // 33-bit window compare so BaseAddr + window size cannot wrap.
  assign addr_ext          = {1'b0, obi_addr_i};
  assign in_window         = (addr_ext >= WinLo) && (addr_ext < WinHi);
  assign offset            = obi_addr_i[IdxW+1:0] - BaseAddr[IdxW+1:0];
  assign unused_offset_lsb = ^offset[1:0];

`ifdef ZEROHETI_OBI_SRAM_ALIGN_ERR_EN
  assign in_range = in_window && (obi_addr_i[1:0] == 2'b00);
`else
  assign in_range = in_window;
`endif

  assign obi_gnt_o = obi_req_i && !rst_i && ((state_q == IDLE) || (state_q == RESP));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    aid_d      = aid_q;
    in_range_d = in_range_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A grant in RESP overrides the return to IDLE for back-to-back service.
    if (obi_gnt_o) begin
      idx_d      = offset[IdxW+1:2];
      we_d       = obi_we_i;
      be_d       = obi_be_i;
      wdata_d    = obi_wdata_i;
      aid_d      = obi_aid_i;
      in_range_d = in_range;
      if (WaitCycles > 0) begin
        state_d = WAIT;
        cnt_d   = 4'(WaitCycles - 1);
      end else begin
        state_d = ACCESS;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      aid_q      <= '0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      aid_q      <= aid_d;
      in_range_q <= in_range_d;
    end
  end

  assign mem_req_o    = !rst_i && (state_q == ACCESS) && in_range_q;
  assign mem_we_o     = mem_req_o && we_q;
  assign mem_addr_o   = mem_req_o ? idx_q : '0;
  assign mem_be_o     = mem_req_o ? be_q : '0;
  assign mem_wdata_o  = mem_req_o ? wdata_q : '0;

  assign obi_rvalid_o = !rst_i && (state_q == RESP);
  assign obi_rdata_o  = (obi_rvalid_o && in_range_q && !we_q) ? mem_rdata_i : '0;
  assign obi_rid_o    = obi_rvalid_o ? aid_q : '0;
  assign obi_err_o    = obi_rvalid_o && !in_range_q;

endmodule

// File: tb/tb_zeroheti_obi_sram_sbr.sv
// tb/tb_zeroheti_obi_sram_sbr.sv - randomized + directed bench, two instances (WaitCycles 0 and 3)
module tb_zeroheti_obi_sram_sbr;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int NW = 1024;
  localparam int W0 = 0;
  localparam int W1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        rst[2], req[2], gnt[2], we[2], aid[2], rvalid[2], rid[2], err[2], mreq[2], mwe[2];
  logic [31:0] addr[2], wdata[2], rdata[2], mwdata[2];
  logic [3:0]  be[2], mbe[2];
  logic [9:0]  maddr[2];
  logic [31:0] mrdata[2] = '{default: '0};
  logic [31:0] sram[2][NW] = '{default: '{default: '0}};
  logic [31:0] ref_mem[2][NW] = '{default: '{default: '0}};

  zeroheti_obi_sram_sbr #(.BaseAddr(BASE), .NumWords(NW), .WaitCycles(W0), .AidWidth(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .obi_req_i(req[0]), .obi_gnt_o(gnt[0]), .obi_addr_i(addr[0]),
    .obi_we_i(we[0]), .obi_be_i(be[0]), .obi_wdata_i(wdata[0]), .obi_aid_i(aid[0]),
    .obi_rvalid_o(rvalid[0]), .obi_rdata_o(rdata[0]), .obi_rid_o(rid[0]), .obi_err_o(err[0]),
    .mem_req_o(mreq[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_be_o(mbe[0]),
    .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata[0]));

  zeroheti_obi_sram_sbr #(.BaseAddr(BASE), .NumWords(NW), .WaitCycles(W1), .AidWidth(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .obi_req_i(req[1]), .obi_gnt_o(gnt[1]), .obi_addr_i(addr[1]),
    .obi_we_i(we[1]), .obi_be_i(be[1]), .obi_wdata_i(wdata[1]), .obi_aid_i(aid[1]),
    .obi_rvalid_o(rvalid[1]), .obi_rdata_o(rdata[1]), .obi_rid_o(rid[1]), .obi_err_o(err[1]),
    .mem_req_o(mreq[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_be_o(mbe[1]),
    .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata[1]));

  // Behavioural single-port SRAM, one-cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mreq[k]) begin
        if (mwe[k]) begin
          for (int b = 0; b < 4; b++)
            if (mbe[k][b]) sram[k][maddr[k]][8*b +: 8] <= mwdata[k][8*b +: 8];
        end else begin
          mrdata[k] <= sram[k][maddr[k]];
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] cyc=%0d actual=%h required=%h", name, k, cyc, act, exp);
    end
  endtask

  function automatic int wc(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    longint x, lo, hi;
    bit ok;
    x  = 64'(a);
    lo = 64'(BASE);
    hi = lo + 4 * NW;
    ok = (x >= lo) && (x < hi);
`ifdef ZEROHETI_OBI_SRAM_ALIGN_ERR_EN
    ok = ok && (a[1:0] == 2'b00);
`endif
    return ok;
  endfunction

  // Reference model: one outstanding transaction, response due at accept+WaitCycles+2.
  bit          m_busy[2] = '{default: 1'b0};
  int          m_due[2], m_idx[2];
  bit          m_inr[2], m_we[2];
  logic [3:0]  m_be[2];
  logic [31:0] m_wd[2], m_rd[2];
  logic        m_aid[2];

  initial begin : compare
    logic e_gnt, e_rv, e_mreq;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) begin
          e_gnt = 1'b0; e_rv = 1'b0; e_mreq = 1'b0;
        end else begin
          e_rv   = m_busy[k] && (m_due[k] == cyc);
          e_gnt  = req[k] && (!m_busy[k] || e_rv);
          e_mreq = m_busy[k] && m_inr[k] && (m_due[k] - 1 == cyc);
        end
        chk("gnt", k, gnt[k], e_gnt);
        chk("rvalid", k, rvalid[k], e_rv);
        chk("rdata", k, rdata[k], e_rv ? m_rd[k] : 32'h0);
        chk("rid", k, rid[k], e_rv ? m_aid[k] : 1'b0);
        chk("err", k, err[k], e_rv && !m_inr[k]);
        chk("mem_req", k, mreq[k], e_mreq);
        chk("mem_we", k, mwe[k], e_mreq && m_we[k]);
        chk("mem_addr", k, maddr[k], e_mreq ? m_idx[k] : 0);
        chk("mem_be", k, mbe[k], e_mreq ? m_be[k] : 4'h0);
        chk("mem_wdata", k, mwdata[k], e_mreq ? m_wd[k] : 32'h0);
        if (e_mreq) begin
          if (m_we[k]) begin
            for (int b = 0; b < 4; b++)
              if (m_be[k][b]) ref_mem[k][m_idx[k]][8*b +: 8] = m_wd[k][8*b +: 8];
          end else begin
            m_rd[k] = ref_mem[k][m_idx[k]];
          end
        end
        if (rst[k] || e_rv) m_busy[k] = 1'b0;
        if (e_gnt) begin
          m_busy[k] = 1'b1;
          m_due[k]  = cyc + wc(k) + 2;
          m_inr[k]  = in_win(addr[k]);
          m_idx[k]  = m_inr[k] ? int'((64'(addr[k]) - 64'(BASE)) / 4) : 0;
          m_we[k]   = we[k];
          m_be[k]   = be[k];
          m_wd[k]   = wdata[k];
          m_aid[k]  = aid[k];
          m_rd[k]   = 32'h0;
        end
      end
    end
  end

  task automatic txn(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                     input logic [31:0] d, input logic id, output logic [31:0] r_data,
                     output logic r_err, output logic r_id, output int lat, output logic seen,
                     output logic [9:0] sa);
    int acc_cyc;
    bit got;
    @(posedge clk); #1;
    req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d; aid[k] = id;
    got = 1'b0; acc_cyc = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt[k]) begin got = 1'b1; acc_cyc = cyc; end
    end
    chk("accept_timeout", k, got, 1);
    @(posedge clk); #1;
    req[k] = 1'b0;
    got = 1'b0; seen = 1'b0; sa = '0; r_data = '0; r_err = 1'b0; r_id = 1'b0; lat = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (mreq[k]) begin seen = 1'b1; sa = maddr[k]; end
      if (rvalid[k]) begin
        got = 1'b1; r_data = rdata[k]; r_err = err[k]; r_id = rid[k]; lat = cyc - acc_cyc;
      end
    end
    chk("resp_timeout", k, got, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(7, 0))
      0, 1, 2: return BASE + 32'($urandom_range(63, 0));
      3, 4:    return BASE + 32'($urandom_range(4 * NW - 1, 0));
      5:       return BASE + 32'(4 * NW) + 32'($urandom_range(7, 0));
      6:       return BASE - 32'd1 - 32'($urandom_range(7, 0));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_run(input int k, input int n);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!req[k] || acc) begin
        req[k]   = ($urandom_range(3, 0) != 0);
        addr[k]  = rand_addr();
        we[k]    = 1'($urandom_range(1, 0));
        be[k]    = 4'($urandom_range(15, 0));
        wdata[k] = $urandom;
        aid[k]   = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
      acc = req[k] && gnt[k];
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        e, id, seen;
    logic [9:0]  sa;
    logic [5:0]  gv, rv;
    int          lat, cnt;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req[k] = 1'b1; addr[k] = BASE; we[k] = 1'b0; be[k] = 4'hF;
      wdata[k] = '0; aid[k] = 1'b0;
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("rst_gnt", k, gnt[k], 0);
        chk("rst_rvalid", k, rvalid[k], 0);
        chk("rst_mem_req", k, mreq[k], 0);
        chk("rst_err", k, err[k], 0);
      end
    end
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk("first_gnt", 0, gnt[0], 1);
    chk("first_gnt", 1, gnt[1], 1);
    @(posedge clk); #1;
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (8) @(posedge clk);

    txn(0, 32'h0001_0010, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, rd, e, id, lat, seen, sa);
    chk("wr_lat", 0, lat, 2);
    chk("wr_err", 0, e, 0);
    chk("wr_mem_addr", 0, sa, 4);
    txn(0, 32'h0001_0010, 1'b0, 4'hF, 32'h0, 1'b1, rd, e, id, lat, seen, sa);
    chk("rd_data", 0, rd, 32'hDEADBEEF);
    chk("rd_rid", 0, id, 1);
    chk("rd_err", 0, e, 0);
    chk("rd_lat", 0, lat, 2);

    txn(1, 32'h0001_1000, 1'b0, 4'hF, 32'h0, 1'b0, rd, e, id, lat, seen, sa);
    chk("oor_hi_err", 1, e, 1);
    chk("oor_hi_rdata", 1, rd, 0);
    chk("oor_hi_lat", 1, lat, 5);
    chk("oor_hi_memreq", 1, seen, 0);
    txn(1, 32'h0000_FFFC, 1'b0, 4'hF, 32'h0, 1'b1, rd, e, id, lat, seen, sa);
    chk("oor_lo_err", 1, e, 1);
    chk("oor_lo_lat", 1, lat, 5);
    chk("oor_lo_memreq", 1, seen, 0);

    @(posedge clk); #1;
    req[0] = 1'b1; addr[0] = 32'h0001_0010; we[0] = 1'b0; aid[0] = 1'b0;
    gv = '0; rv = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gv[i] = gnt[0];
      rv[i] = rvalid[0];
      if (i == 2) begin
        @(posedge clk); #1;
        req[0] = 1'b0;
      end
    end
    chk("b2b_gnt", 0, gv, 6'b000101);
    chk("b2b_rvalid", 0, rv, 6'b010100);

    txn(0, 32'h0001_0020, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, e, id, lat, seen, sa);
    txn(0, 32'h0001_0020, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, rd, e, id, lat, seen, sa);
    txn(0, 32'h0001_0020, 1'b0, 4'hF, 32'h0, 1'b0, rd, e, id, lat, seen, sa);
    chk("partial_wr", 0, rd, 32'hFFFF_5678);

    txn(0, 32'h0001_0030, 1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b1, rd, e, id, lat, seen, sa);
    chk("be0_memreq", 0, seen, 1);
    chk("be0_err", 0, e, 0);
    txn(0, 32'h0001_0030, 1'b0, 4'hF, 32'h0, 1'b1, rd, e, id, lat, seen, sa);
    chk("be0_readback", 0, rd, 32'h0);

    txn(0, 32'h0001_0000, 1'b1, 4'hF, 32'hA5A5_0001, 1'b0, rd, e, id, lat, seen, sa);
    txn(0, 32'h0001_0002, 1'b0, 4'hF, 32'h0, 1'b0, rd, e, id, lat, seen, sa);
`ifdef ZEROHETI_OBI_SRAM_ALIGN_ERR_EN
    chk("misalign_err", 0, e, 1);
    chk("misalign_rdata", 0, rd, 32'h0);
    chk("misalign_memreq", 0, seen, 0);
`else
    chk("misalign_err", 0, e, 0);
    chk("misalign_rdata", 0, rd, 32'hA5A5_0001);
    chk("misalign_memreq", 0, seen, 1);
`endif

    @(posedge clk); #1;
    req[1] = 1'b1; addr[1] = BASE + 32'd8; we[1] = 1'b0;
    @(negedge clk);
    chk("mid_accept", 1, gnt[1], 1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rvalid[1]) cnt++;
    end
    chk("mid_rst_rvalid", 1, cnt, 0);

    rand_run(0, 1500);
    rand_run(1, 1500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
